psum_drain_packer: RTL and testbench

- Downstream drain stage of accelerator_port.
- Consumes the two reduced psum read streams from the psum GBF banks: reduced_r_data1b qualified by r_en1b_out, and reduced_r_data2b qualified by r_en2b_out.
- Packs consecutive beats of each bank into full 256-bit words and buffers them in a shared FIFO.
- Hands the words to the off-chip writer over a valid/ready handshake.
- The accelerator cannot be stalled, so input beats are never back-pressured; loss is flagged instead.

---
 rtl/psum_drain_packer.sv | 145 ++++++++++++++
 tb/tb_psum_drain_packer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain_packer.sv
// Packs two 128-bit reduced psum streams into 256-bit words and buffers them in a shared FIFO.
// Optional per-bank pop counters are enabled with the PSUM_DRAIN_STAT_EN macro.
module psum_drain_packer #(
    parameter int PSUM_GBF_DATA_BITWIDTH = 512,
    parameter int OUT_BITWIDTH_PK        = 256,
    parameter int FIFO_DEPTH             = 8,
    parameter int FIFO_ADDR_BITWIDTH     = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [PSUM_GBF_DATA_BITWIDTH/4-1:0] reduced_r_data1b,
    input  logic                                r_en1b_out,
    input  logic [PSUM_GBF_DATA_BITWIDTH/4-1:0] reduced_r_data2b,
    input  logic                                r_en2b_out,
    input  logic                                flush,
    output logic [OUT_BITWIDTH_PK-1:0]          out_data,
    output logic                                out_bank,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [FIFO_ADDR_BITWIDTH:0]         fifo_count,
    output logic                                overflow,
`ifdef PSUM_DRAIN_STAT_EN
    output logic [15:0]                         words_out_b1,
    output logic [15:0]                         words_out_b2,
`endif
    output logic                                idle
);

    localparam int IN_W   = PSUM_GBF_DATA_BITWIDTH / 4;
    localparam int AW     = FIFO_ADDR_BITWIDTH;
    localparam int FREE_W = FIFO_ADDR_BITWIDTH + 2;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    pack_state_t                st     [2];
    pack_state_t                st_nxt [2];
    logic [IN_W-1:0]            low    [2];
    logic [IN_W-1:0]            low_nxt[2];
    logic                       beat_v [2];
    logic [IN_W-1:0]            beat_d [2];
    logic                       done   [2];
    logic [OUT_BITWIDTH_PK-1:0] word   [2];

    assign beat_v[0] = r_en1b_out;
    assign beat_v[1] = r_en2b_out;
    assign beat_d[0] = reduced_r_data1b;
    assign beat_d[1] = reduced_r_data2b;

    // Flush looks at the state after this cycle's beat, so a lone beat plus flush emits {0, beat}.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            st_nxt[b]  = st[b];
            low_nxt[b] = low[b];
            done[b]    = 1'b0;
            word[b]    = '0;
            if (beat_v[b]) begin
                if (st[b] == HALF) begin
                    word[b]   = {beat_d[b], low[b]};
                    done[b]   = 1'b1;
                    st_nxt[b] = EMPTY;
                end else begin
                    low_nxt[b] = beat_d[b];
                    st_nxt[b]  = HALF;
                end
            end
            if (flush && (st_nxt[b] == HALF)) begin
                word[b]   = {{IN_W{1'b0}}, low_nxt[b]};
                done[b]   = 1'b1;
                st_nxt[b] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                st[b]  <= EMPTY;
                low[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                st[b]  <= st_nxt[b];
                low[b] <= low_nxt[b];
            end
        end
    end

    logic [OUT_BITWIDTH_PK:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr, wr_ptr_p1, addr2;
    logic [FREE_W-1:0]        free;
    logic [AW:0]              n_push;
    logic                     pop, acc1, acc2, drop;
    logic [OUT_BITWIDTH_PK:0] head;

    assign pop       = out_valid & out_ready;
    assign free      = FREE_W'(FIFO_DEPTH) - {1'b0, fifo_count} + {{(FREE_W-1){1'b0}}, pop};
    // Bank1 has priority for the free slots, so bank2 is the first to be dropped.
    assign acc1      = done[0] && (free != '0);
    assign acc2      = done[1] && (acc1 ? (free >= FREE_W'(2)) : (free != '0));
    assign drop      = (done[0] & ~acc1) | (done[1] & ~acc2);
    assign n_push    = {{AW{1'b0}}, acc1} + {{AW{1'b0}}, acc2};
    assign wr_ptr_p1 = wr_ptr + 1'b1;
    assign addr2     = acc1 ? wr_ptr_p1 : wr_ptr;

    always_ff @(posedge clk) begin
        if (acc1) mem[wr_ptr] <= {1'b0, word[0]};
        if (acc2) mem[addr2]  <= {1'b1, word[1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + n_push[AW-1:0];
            rd_ptr     <= rd_ptr + {{(AW-1){1'b0}}, pop};
            fifo_count <= fifo_count + n_push - {{AW{1'b0}}, pop};
            if (drop) overflow <= 1'b1;
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? head[OUT_BITWIDTH_PK-1:0] : '0;
    assign out_bank  = out_valid & head[OUT_BITWIDTH_PK];
    assign idle      = (fifo_count == '0) && (st[0] == EMPTY) && (st[1] == EMPTY);

`ifdef PSUM_DRAIN_STAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_out_b1 <= '0;
            words_out_b2 <= '0;
        end else if (pop) begin
            if (!out_bank && (words_out_b1 != 16'hFFFF)) words_out_b1 <= words_out_b1 + 16'd1;
            if (out_bank && (words_out_b2 != 16'hFFFF))  words_out_b2 <= words_out_b2 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_psum_drain_packer.sv
// Self-checking bench for psum_drain_packer: bench-side pack model feeds an expected-word queue.
module tb_psum_drain_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] reduced_r_data1b, reduced_r_data2b;
    logic         r_en1b_out, r_en2b_out, flush, out_ready;
    logic [255:0] out_data;
    logic         out_bank, out_valid, overflow, idle;
    logic [3:0]   fifo_count;
`ifdef PSUM_DRAIN_STAT_EN
    logic [15:0]  words_out_b1, words_out_b2;
`endif

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int pops_b1 = 0;
    int pops_b2 = 0;

    logic [256:0] exp_q[$];
    logic         m_half[2];
    logic [127:0] m_low[2];

    always #5 clk = ~clk;

    psum_drain_packer dut (
        .clk(clk), .reset(reset),
        .reduced_r_data1b(reduced_r_data1b), .r_en1b_out(r_en1b_out),
        .reduced_r_data2b(reduced_r_data2b), .r_en2b_out(r_en2b_out),
        .flush(flush), .out_data(out_data), .out_bank(out_bank),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
        .overflow(overflow),
`ifdef PSUM_DRAIN_STAT_EN
        .words_out_b1(words_out_b1), .words_out_b2(words_out_b2),
`endif
        .idle(idle)
    );

    // Output side of the scoreboard: every accepted word must match the queue head.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            logic [256:0] exp;
            checks++;
            pops++;
            if (out_bank) pops_b2++; else pops_b1++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got bank=%0d data=%h, required no word", out_bank, out_data);
            end else begin
                exp = exp_q.pop_front();
                if ({out_bank, out_data} !== exp) begin
                    errors++;
                    $display("FAIL pop_word: got bank=%0d data=%h, required bank=%0d data=%h",
                             out_bank, out_data, exp[256], exp[255:0]);
                end
            end
        end
    end

    task automatic clear_model();
        for (int b = 0; b < 2; b++) begin
            m_half[b] = 1'b0;
            m_low[b]  = '0;
        end
        exp_q.delete();
    endtask

    task automatic drive(input logic v1, input logic [127:0] d1,
                         input logic v2, input logic [127:0] d2, input logic fl);
        logic         v[2];
        logic [127:0] d[2];
        @(posedge clk); #1;
        r_en1b_out = v1; reduced_r_data1b = d1;
        r_en2b_out = v2; reduced_r_data2b = d2;
        flush = fl;
        v[0] = v1; v[1] = v2; d[0] = d1; d[1] = d2;
        for (int b = 0; b < 2; b++) begin
            logic         c;
            logic [255:0] w;
            c = 1'b0;
            w = '0;
            if (v[b]) begin
                if (m_half[b]) begin
                    w = {d[b], m_low[b]}; c = 1'b1; m_half[b] = 1'b0;
                end else begin
                    m_low[b] = d[b]; m_half[b] = 1'b1;
                end
            end
            if (fl && m_half[b]) begin
                w = {128'h0, m_low[b]}; c = 1'b1; m_half[b] = 1'b0;
            end
            if (c && exp_q.size() < 8) exp_q.push_back({b[0], w});
        end
    endtask

    task automatic idle_cycle();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            idle_cycle();
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain_timeout: got %0d words left, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_en1b_out = 1'b1; reduced_r_data1b = 128'(i + 1);
            r_en2b_out = 1'b1; reduced_r_data2b = 128'(i + 9);
            @(posedge clk); #1;
        end
        clear_model();
        pops = 0; pops_b1 = 0; pops_b2 = 0;
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0 || idle !== 1'b1 ||
            out_data !== 256'h0 || out_bank !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0d count=%0d ovf=%0d idle=%0d, required 0 0 0 1",
                     out_valid, fifo_count, overflow, idle);
        end
        r_en1b_out = 1'b0; r_en2b_out = 1'b0;
        reset = 1'b1;
        idle_cycle();
        checks++;
        if (idle !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got idle=%0d valid=%0d, required 1 0", idle, out_valid);
        end
    endtask

    task automatic test_bank1_pack();
        out_ready = 1'b1;
        drive(1'b1, 128'hA, 1'b0, '0, 1'b0);
        drive(1'b1, 128'hB, 1'b0, '0, 1'b0);
        idle_cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {128'hB, 128'hA} || out_bank !== 1'b0) begin
            errors++;
            $display("FAIL bank1_latency: got valid=%0d bank=%0d data=%h, required 1 0 {B,A}",
                     out_valid, out_bank, out_data);
        end
        idle_cycle();
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL bank1_count_after_pop: got %0d, required 0", fifo_count);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        drive(1'b1, 128'h1, 1'b1, 128'h3, 1'b0);
        drive(1'b1, 128'h2, 1'b1, 128'h4, 1'b0);
        idle_cycle();
        checks++;
        if (fifo_count !== 4'd2 || out_data !== {128'h2, 128'h1} || out_bank !== 1'b0) begin
            errors++;
            $display("FAIL simul_push: got count=%0d bank=%0d data=%h, required 2 0 {2,1}",
                     fifo_count, out_bank, out_data);
        end
        wait_drain("simul");
    endtask

    task automatic test_overflow();
        int p0;
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 128'(2 * k + 16), 1'b0, '0, 1'b0);
            drive(1'b1, 128'(2 * k + 17), 1'b0, '0, 1'b0);
        end
        idle_cycle();
        idle_cycle();
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full: got count=%0d ovf=%0d, required 8 1", fifo_count, overflow);
        end
        checks++;
        if (out_data !== {128'd17, 128'd16}) begin
            errors++;
            $display("FAIL overflow_head_hold: got %h, required {17,16}", out_data);
        end
        p0 = pops;
        wait_drain("overflow");
        checks++;
        if (pops - p0 != 8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drain: got %0d words ovf=%0d, required 8 words ovf=1", pops - p0, overflow);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b0, '0, 1'b1, 128'h5, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        idle_cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {128'h0, 128'h5} || out_bank !== 1'b1) begin
            errors++;
            $display("FAIL flush_bank2: got valid=%0d bank=%0d data=%h, required 1 1 {0,5}",
                     out_valid, out_bank, out_data);
        end
        drive(1'b1, 128'hC, 1'b0, '0, 1'b1);
        wait_drain("flush");
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: got %0d, required 1", idle);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) drive(1'b1, 128'(i + 32), 1'b0, '0, 1'b0);
        idle_cycle();
        checks++;
        if (fifo_count !== 4'd3 || idle !== 1'b0) begin
            errors++;
            $display("FAIL mid_prefill: got count=%0d idle=%0d, required 3 0", fifo_count, idle);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (fifo_count !== 4'd0 || out_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_reset: got count=%0d valid=%0d idle=%0d, required 0 0 1",
                     fifo_count, out_valid, idle);
        end
        clear_model();
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 128'h7, 1'b0, '0, 1'b0);
        drive(1'b1, 128'h8, 1'b0, '0, 1'b0);
        wait_drain("mid");
    endtask

    task automatic test_random();
        test_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        wait_drain("random");
        checks++;
        if (overflow !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL random_final: got ovf=%0d idle=%0d, required 0 1", overflow, idle);
        end
`ifdef PSUM_DRAIN_STAT_EN
        checks++;
        if (words_out_b1 !== 16'(pops_b1) || words_out_b2 !== 16'(pops_b2)) begin
            errors++;
            $display("FAIL stat_counts: got %0d/%0d, required %0d/%0d",
                     words_out_b1, words_out_b2, pops_b1, pops_b2);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        r_en1b_out = 1'b0; r_en2b_out = 1'b0;
        reduced_r_data1b = '0; reduced_r_data2b = '0;
        flush = 1'b0; out_ready = 1'b0;
        clear_model();
        test_reset();
        test_bank1_pack();
        test_simultaneous();
        test_overflow();
        test_reset();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
